servo_pwm_capture: RTL and testbench
====================================

# servo_pwm_capture

Measures an incoming hobby-servo PWM signal, reporting high time and period in clk_pwm cycles. It validates each pulse against the servo pulse window and flags loss of signal. It is the receive-side counterpart to the servo PWM generator. It sits on the clk_pwm domain and is used for closed-loop checking of generated servo pulses or for decoding an external RC/servo command into an angle count.

## Interface
Parameters:
- MIN_W, 24_000: shortest accepted high time, in cycles (0° pulse).
- MAX_W, 126_000: longest accepted high time, in cycles (180° pulse).
- TIMEOUT, 2_000_000: cycles without the expected edge before loss is declared.
- FILT_LEN, 4: glitch-filter length in cycles. Used only with SERVO_CAP_FILTER_EN.

Ports:
- clk_pwm, input, 1: sole clock.
- rst, input, 1: asynchronous, active-low reset.
- sw_en, input, 1: capture enable. Synchronous, active-high.
- pwm_in, input, 1: asynchronous PWM input.
- width, output, 32: last accepted high time, in cycles.
- period, output, 32: last accepted rise-to-rise time, in cycles.
- angle_valid, output, 1: one-cycle strobe when width and period update.
- range_err, output, 1: one-cycle strobe when a complete pulse falls outside [MIN_W, MAX_W].
- signal_lost, output, 1: level. Set on timeout; cleared on the next angle_valid.

## Operation
- pwm_in passes through a 2-flop synchronizer, then the optional filter, giving level `s`.
- A registered copy of `s` provides the rise and fall edge detects.
- State SYNC (entered at reset, on sw_en low, and on timeout):
  - Wait for `s` = 0, then go to ARMED.
  - Discards any pulse already in progress.
- State ARMED:
  - On rise, clear hi_cnt to 1 and go to HIGH.
- State HIGH:
  - hi_cnt increments each cycle while `s` = 1.
  - On fall, hold hi_cnt, set lo_cnt to 1 and go to LOW.
- State LOW:
  - lo_cnt increments each cycle while `s` = 0.
  - On rise, evaluate the pulse, then go to HIGH with hi_cnt = 1 and lo_cnt = 0.
- Pulse evaluation:
  - If MIN_W ≤ hi_cnt ≤ MAX_W:
    - width ← hi_cnt.
    - period ← hi_cnt + lo_cnt (32-bit, no overflow possible below TIMEOUT).
    - Pulse angle_valid.
    - Clear signal_lost.
  - Otherwise, pulse range_err; width and period hold.
- Timeout:
  - Each state counter (ARMED wait, hi_cnt, lo_cnt) saturates at TIMEOUT.
  - Reaching TIMEOUT in ARMED, HIGH or LOW sets signal_lost and goes to SYNC.
  - No strobe is issued on timeout.
  - SYNC waits without a timer.
- sw_en low:
  - State is forced to SYNC and counters are cleared.
  - width, period and signal_lost hold.
  - No strobes are issued.
- Reset values:
  - width = 75_000 (90°), period = 0.
  - angle_valid = 0, range_err = 0.
  - signal_lost = 1.
  - State SYNC, counters 0.
- angle_valid and range_err are never asserted in the same cycle.

## Timing
- Measured hi_cnt equals the number of clk_pwm edges that sample pwm_in high. Synchronizer and filter delays cancel between rise and fall.
- Strobe latency: angle_valid or range_err is asserted 3 cycles after the first clk_pwm edge that samples the closing rise of pwm_in high. Add FILT_LEN cycles with the filter.
- width and period change in the same cycle angle_valid is high and are stable until the next strobe.
- The first strobe after reset, enable or timeout follows the second complete rise. Minimum is one full pulse plus one rise.
- A rise and a timeout in the same cycle: the timeout wins, and the pulse is discarded.
- Asserting rst mid-pulse clears everything immediately; outputs take their reset values asynchronously.

## Configuration
- SERVO_CAP_FILTER_EN defined:
  - `s` changes only after the synchronized input holds a new level for FILT_LEN consecutive cycles.
  - Shorter glitches are ignored.
- Not defined:
  - `s` is the synchronizer output directly.
  - FILT_LEN is unused.
  - Every transition is an edge.

## Test plan
- 1.5 ms high / 18.5 ms low at 50 MHz, three periods -> two angle_valid strobes with width = 75_000, period = 1_000_000; signal_lost falls at the first strobe.
- 0.3 ms pulse (15_000) after a valid pulse -> range_err for one cycle; width stays 75_000; no angle_valid.
- rst released while pwm_in is high mid-pulse -> that pulse is discarded; the first strobe follows the second full rise.
- pwm_in held low 40 ms after lock -> signal_lost = 1 exactly TIMEOUT cycles after the last fall; no strobe; the next two valid pulses give angle_valid and clear signal_lost.
- 2-cycle low glitch inside a 75_000-cycle pulse:
  - With SERVO_CAP_FILTER_EN -> width = 75_000.
  - Without -> range_err at the glitch-induced rise, since the truncated pulse is below MIN_W.
- sw_en dropped mid-HIGH for 100 cycles -> no strobe for that pulse; outputs hold; normal strobes resume after resync.

Source files
------------

// File: rtl/servo_pwm_capture.sv
// servo_pwm_capture: measures servo PWM high time and period on clk_pwm.
// Ports: clk_pwm, rst (async, active-low), sw_en, pwm_in -> width, period,
//   angle_valid, range_err, signal_lost. Option: SERVO_CAP_FILTER_EN.
module servo_pwm_capture #(
  parameter int unsigned MIN_W    = 24_000,
  parameter int unsigned MAX_W    = 126_000,
  parameter int unsigned TIMEOUT  = 2_000_000,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic        clk_pwm,
  input  logic        rst,
  input  logic        sw_en,
  input  logic        pwm_in,
  output logic [31:0] width,
  output logic [31:0] period,
  output logic        angle_valid,
  output logic        range_err,
  output logic        signal_lost
);

  typedef enum logic [1:0] {
    SYNC, ARMED, HIGH, LOW
  } state_t;

  // Fill counter is sized for the longest (filtered) input pipeline.
  localparam int FW = $clog2(4 + FILT_LEN);

  logic s1, s2, s, s_q;
  logic rise, fall;
  logic [FW-1:0] fill;
  logic pipe_ok;

  always_ff @(posedge clk_pwm or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef SERVO_CAP_FILTER_EN
  localparam int unsigned PIPE = 3 + FILT_LEN;
  localparam int FCW = $clog2(FILT_LEN + 1);

  logic [FCW-1:0] f_cnt;
  logic s_f;

  always_ff @(posedge clk_pwm or negedge rst) begin
    if (!rst) begin
      f_cnt <= '0;
      s_f   <= 1'b0;
    end else if (s2 == s_f) begin
      f_cnt <= '0;
    end else if (f_cnt == FCW'(FILT_LEN - 1)) begin
      s_f   <= s2;
      f_cnt <= '0;
    end else begin
      f_cnt <= f_cnt + 1'b1;
    end
  end

  assign s = s_f;
`else
  localparam int unsigned PIPE = 3;

  assign s = s2;
`endif

  // fill marks when s_q holds a real sample rather than the reset zero,
  // so a pulse already high at reset is not mistaken for a fresh rise.
  always_ff @(posedge clk_pwm or negedge rst) begin
    if (!rst) begin
      s_q  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      fill <= '0;
    end else begin
      s_q  <= s;
      rise <= s & ~s_q;
      fall <= ~s & s_q;
      if (fill != FW'(PIPE))
        fill <= fill + 1'b1;
    end
  end

  assign pipe_ok = (fill == FW'(PIPE));

  state_t state, state_d;
  logic [31:0] hi_cnt, hi_d;
  logic [31:0] lo_cnt, lo_d;
  logic [31:0] width_d, period_d;
  logic av_d, re_d, lost_d;
  logic in_range;

  always_ff @(posedge clk_pwm or negedge rst) begin
    if (!rst) begin
      state       <= SYNC;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      width       <= 32'd75_000;
      period      <= '0;
      angle_valid <= 1'b0;
      range_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      state       <= state_d;
      hi_cnt      <= hi_d;
      lo_cnt      <= lo_d;
      width       <= width_d;
      period      <= period_d;
      angle_valid <= av_d;
      range_err   <= re_d;
      signal_lost <= lost_d;
    end
  end

  assign in_range = (hi_cnt >= MIN_W) && (hi_cnt <= MAX_W);

  // lo_cnt doubles as the ARMED wait timer.
  always_comb begin
    state_d  = state;
    hi_d     = hi_cnt;
    lo_d     = lo_cnt;
    width_d  = width;
    period_d = period;
    av_d     = 1'b0;
    re_d     = 1'b0;
    lost_d   = signal_lost;
    if (!sw_en) begin
      state_d = SYNC;
      hi_d    = '0;
      lo_d    = '0;
    end else begin
      unique case (state)
        SYNC: begin
          hi_d = '0;
          lo_d = '0;
          if (pipe_ok && !s_q)
            state_d = ARMED;
        end
        ARMED: begin
          if (lo_cnt == TIMEOUT) begin
            lost_d  = 1'b1;
            state_d = SYNC;
            lo_d    = '0;
          end else if (rise) begin
            hi_d    = 32'd1;
            lo_d    = '0;
            state_d = HIGH;
          end else begin
            lo_d = lo_cnt + 32'd1;
          end
        end
        HIGH: begin
          if (hi_cnt == TIMEOUT) begin
            lost_d  = 1'b1;
            state_d = SYNC;
            hi_d    = '0;
            lo_d    = '0;
          end else if (fall) begin
            lo_d    = 32'd1;
            state_d = LOW;
          end else begin
            hi_d = hi_cnt + 32'd1;
          end
        end
        LOW: begin
          if (lo_cnt == TIMEOUT) begin
            lost_d  = 1'b1;
            state_d = SYNC;
            hi_d    = '0;
            lo_d    = '0;
          end else if (rise) begin
            if (in_range) begin
              width_d  = hi_cnt;
              period_d = hi_cnt + lo_cnt;
              av_d     = 1'b1;
              lost_d   = 1'b0;
            end else begin
              re_d = 1'b1;
            end
            hi_d    = 32'd1;
            lo_d    = '0;
            state_d = HIGH;
          end else begin
            lo_d = lo_cnt + 32'd1;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// tb_servo_pwm_capture: directed checks of servo_pwm_capture with
// scaled-down pulse window and timeout.
module tb_servo_pwm_capture;

  localparam int unsigned MIN_W    = 24;
  localparam int unsigned MAX_W    = 126;
  localparam int unsigned TIMEOUT  = 2000;
  localparam int unsigned FILT_LEN = 4;
`ifdef SERVO_CAP_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif

  logic clk_pwm = 1'b0;
  logic rst;
  logic sw_en;
  logic pwm_in;
  logic [31:0] width;
  logic [31:0] period;
  logic angle_valid;
  logic range_err;
  logic signal_lost;

  servo_pwm_capture #(
    .MIN_W   (MIN_W),
    .MAX_W   (MAX_W),
    .TIMEOUT (TIMEOUT),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk_pwm    (clk_pwm),
    .rst        (rst),
    .sw_en      (sw_en),
    .pwm_in     (pwm_in),
    .width      (width),
    .period     (period),
    .angle_valid(angle_valid),
    .range_err  (range_err),
    .signal_lost(signal_lost)
  );

  always #5 clk_pwm = ~clk_pwm;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int av_cnt = 0;
  int re_cnt = 0;
  int strobe_cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;

  always @(posedge clk_pwm) cyc <= cyc + 1;

  always @(negedge clk_pwm) begin
    if (angle_valid || range_err) begin
      checks++;
      strobe_cyc = cyc;
      if (angle_valid) av_cnt++;
      if (range_err) re_cnt++;
      if (angle_valid && range_err) begin
        errors++;
        $display("FAIL both_strobes: cycle %0d got both high, need one", cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    @(negedge clk_pwm);
    pwm_in = lvl;
    if (lvl) rise_cyc = cyc + 1;
    else fall_cyc = cyc + 1;
    repeat (n - 1) @(negedge clk_pwm);
  endtask

  task automatic pulse(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  typedef struct {
    int hi;
    int lo;
    int av;
    int re;
    int w;
    int p;
    int lost;
  } vec_t;

  vec_t tbl[12];
  int a0, r0;

  initial begin
    tbl[0]  = '{75, 925, 0, 0, 75000, 0, 1};
    tbl[1]  = '{75, 925, 1, 0, 75, 1000, 0};
    tbl[2]  = '{75, 925, 1, 0, 75, 1000, 0};
    tbl[3]  = '{15, 985, 1, 0, 75, 1000, 0};
    tbl[4]  = '{75, 925, 0, 1, 75, 1000, 0};
    tbl[5]  = '{100, 400, 1, 0, 75, 1000, 0};
    tbl[6]  = '{126, 374, 1, 0, 100, 500, 0};
    tbl[7]  = '{24, 476, 1, 0, 126, 500, 0};
    tbl[8]  = '{127, 373, 1, 0, 24, 500, 0};
    tbl[9]  = '{23, 477, 0, 1, 24, 500, 0};
    tbl[10] = '{50, 950, 0, 1, 24, 500, 0};
    tbl[11] = '{75, 925, 1, 0, 50, 1000, 0};

    rst = 1'b0;
    sw_en = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk_pwm);
    chk("rst_width", width, 32'd75000);
    chk("rst_period", period, 32'd0);
    chk("rst_av", {31'd0, angle_valid}, 32'd0);
    chk("rst_re", {31'd0, range_err}, 32'd0);
    chk("rst_lost", {31'd0, signal_lost}, 32'd1);
    rst = 1'b1;
    repeat (10) @(negedge clk_pwm);

    for (int i = 0; i < 12; i++) begin
      a0 = av_cnt;
      r0 = re_cnt;
      pulse(tbl[i].hi, tbl[i].lo);
      chk($sformatf("v%0d_av", i), av_cnt - a0, tbl[i].av);
      chk($sformatf("v%0d_re", i), re_cnt - r0, tbl[i].re);
      chk($sformatf("v%0d_width", i), width, tbl[i].w);
      chk($sformatf("v%0d_period", i), period, tbl[i].p);
      chk($sformatf("v%0d_lost", i), {31'd0, signal_lost}, tbl[i].lost);
      if (tbl[i].av + tbl[i].re > 0)
        chk($sformatf("v%0d_latency", i), strobe_cyc - rise_cyc, LAT);
    end

    a0 = av_cnt;
    r0 = re_cnt;
    for (int k = 0; k < 3 * TIMEOUT && !signal_lost; k++)
      @(negedge clk_pwm);
    chk("to_lost", {31'd0, signal_lost}, 32'd1);
    chk("to_time", cyc - fall_cyc, TIMEOUT + LAT);
    chk("to_av", av_cnt - a0, 0);
    chk("to_re", re_cnt - r0, 0);
    pulse(75, 925);
    chk("rel1_av", av_cnt - a0, 0);
    chk("rel1_lost", {31'd0, signal_lost}, 32'd1);
    pulse(75, 925);
    chk("rel2_av", av_cnt - a0, 1);
    chk("rel2_lost", {31'd0, signal_lost}, 32'd0);
    chk("rel2_width", width, 32'd75);
    chk("rel2_period", period, 32'd1000);
    pulse(75, 925);

    a0 = av_cnt;
    r0 = re_cnt;
    drive(1'b1, 10);
    sw_en = 1'b0;
    repeat (100) @(negedge clk_pwm);
    chk("en_hold_width", width, 32'd75);
    chk("en_hold_period", period, 32'd1000);
    chk("en_hold_lost", {31'd0, signal_lost}, 32'd0);
    sw_en = 1'b1;
    repeat (10) @(negedge clk_pwm);
    drive(1'b0, 880);
    chk("en_a_av", av_cnt - a0, 1);
    pulse(75, 925);
    chk("en_b_av", av_cnt - a0, 1);
    chk("en_b_re", re_cnt - r0, 0);
    pulse(75, 925);
    chk("en_c_av", av_cnt - a0, 2);
    chk("en_c_width", width, 32'd75);

    a0 = av_cnt;
    r0 = re_cnt;
    drive(1'b1, 10);
    drive(1'b0, 2);
    drive(1'b1, 63);
    drive(1'b0, 925);
    pulse(75, 925);
`ifdef SERVO_CAP_FILTER_EN
    chk("glitch_re", re_cnt - r0, 0);
    chk("glitch_width", width, 32'd75);
    chk("glitch_period", period, 32'd1000);
`else
    chk("glitch_re", re_cnt - r0, 1);
    chk("glitch_width", width, 32'd63);
    chk("glitch_period", period, 32'd988);
`endif
    chk("glitch_av", av_cnt - a0, 2);

    drive(1'b1, 40);
    rst = 1'b0;
    #1;
    chk("arst_width", width, 32'd75000);
    chk("arst_period", period, 32'd0);
    chk("arst_lost", {31'd0, signal_lost}, 32'd1);
    repeat (2) @(negedge clk_pwm);
    rst = 1'b1;
    a0 = av_cnt;
    r0 = re_cnt;
    repeat (30) @(negedge clk_pwm);
    drive(1'b0, 925);
    pulse(75, 925);
    chk("arst1_av", av_cnt - a0, 0);
    chk("arst1_re", re_cnt - r0, 0);
    pulse(75, 925);
    chk("arst2_av", av_cnt - a0, 1);
    chk("arst2_width", width, 32'd75);
    chk("arst2_period", period, 32'd1000);
    chk("arst2_lost", {31'd0, signal_lost}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
